muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage.
- Consumes the same A/B operand pair that drives the ALU, and owns the HI/LO registers.
- Serves mult/multu/div/divu, mthi/mtlo writes and mfhi/mflo reads.
- Its busy output feeds the hazard unit, which stalls any HI/LO-touching instruction in ID.

---
 rtl/muldiv_unit.sv | 110 +++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Results are computed at the start edge and committed after a fixed busy window.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [63:0]      r_pend;
    logic             r_pend_wr;
    logic [31:0]      r_hi, r_lo;

    logic             w_load, w_commit, w_mt_we;
    logic             w_sdiv;
    logic [31:0]      w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [63:0]      w_smul, w_umul, w_result;
    logic             w_result_wr;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign w_sdiv  = (op == 2'b10);
    assign w_a_mag = (w_sdiv && A[31]) ? (~A + 32'd1) : A;
    assign w_b_mag = (w_sdiv && B[31]) ? (~B + 32'd1) : B;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quot  = (w_sdiv && (A[31] ^ B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = (w_sdiv && A[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_umul = {32'd0, A} * {32'd0, B};

    assign w_result    = op[1] ? {w_rem, w_quot} : (op[0] ? w_umul : w_smul);
    assign w_result_wr = !(op[1] && (B == 32'd0));

    assign w_mt_we = (r_state == S_IDLE) && !start && hilo_we;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_wr <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_pend    <= w_result;
                r_pend_wr <= w_result_wr;
            end
            if (w_commit && r_pend_wr) begin
                {r_hi, r_lo} <= r_pend;
            end else if (w_mt_we) begin
                if (hilo_sel) r_hi <= A;
                else          r_lo <= A;
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign rd_data = hilo_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table for arithmetic and
// hand-written sequences for reset, contention and abort.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        hilo_we, hilo_sel;
    logic        busy;
    logic [31:0] hi, lo, rd_data;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] val);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        A        = val;
        tick();
        hilo_we  = 1'b0;
    endtask

    // Issues a one-cycle start pulse and returns with the start edge just passed.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    initial begin
        int n;
        logic early;

        vecs[0] = '{"mult_neg",   2'b00, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{"multu",      2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{"div_neg",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{"divu",       2'b11, 32'h00000007, 32'h00000002, 32'h0, 32'h0, 32'h00000001, 32'h00000003, 10};
        vecs[4] = '{"divu_by0",   2'b11, 32'h00000064, 32'h00000000, 32'h5678, 32'h1234, 32'h00005678, 32'h00001234, 10};
        vecs[5] = '{"div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h5678, 32'h1234, 32'h00000000, 32'h80000000, 10};
        vecs[6] = '{"div_negdiv", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{"mult_carry", 2'b00, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 5};
        vecs[8] = '{"div_by0",    2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hCAFE, 32'hBEEF, 32'h0000CAFE, 32'h0000BEEF, 10};

        rst_n = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0;

        // Reset at time zero, observed before the first clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst0_busy", 64'(busy), 64'd0);
        check("rst0_hilo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-cycle while a div is running clears everything at once.
        mt_write(1'b0, 32'hBBBB);
        mt_write(1'b1, 32'hAAAA);
        hilo_sel = 1'b1;
        #1 check("mthi_rd", 64'(rd_data), 64'h0000AAAA);
        hilo_sel = 1'b0;
        #1 check("mtlo_rd", 64'(rd_data), 64'h0000BBBB);
        issue(2'b10, 32'd100, 32'd3);
        tick();
        tick();
        check("abort_busy_pre", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_commit", {hi, lo}, 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // Table-driven arithmetic vectors.
        for (int v = 0; v < 9; v++) begin
            mt_write(1'b0, vecs[v].pre_lo);
            mt_write(1'b1, vecs[v].pre_hi);
            hilo_sel = 1'b0;
            #1 check({vecs[v].name, "_prelo"}, 64'(rd_data), 64'(vecs[v].pre_lo));
            issue(vecs[v].op, vecs[v].a, vecs[v].b);
            n = 0;
            early = 1'b0;
            while (busy && n < 50) begin
                if ({hi, lo} !== {vecs[v].pre_hi, vecs[v].pre_lo}) early = 1'b1;
                tick();
                n++;
            end
            check({vecs[v].name, "_cycles"}, 64'(n), 64'(vecs[v].cycles));
            check({vecs[v].name, "_early"}, 64'(early), 64'd0);
            check({vecs[v].name, "_lo"}, 64'(lo), 64'(vecs[v].exp_lo));
            hilo_sel = 1'b1;
            #1 check({vecs[v].name, "_rdhi"}, 64'(rd_data), 64'(vecs[v].exp_hi));
        end

        // Start and hilo_we during a running mult are ignored.
        mt_write(1'b0, 32'h22);
        mt_write(1'b1, 32'h11);
        issue(2'b00, 32'd3, 32'd4);
        n = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd7;
            hilo_we = 1'b1; hilo_sel = i[0];
            tick();
            n++;
        end
        start = 1'b0; hilo_we = 1'b0;
        check("cont_hilo_hold", {hi, lo}, {32'h11, 32'h22});
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("cont_cycles", 64'(n), 64'd5);
        check("cont_result", {hi, lo}, {32'h0, 32'hC});
        for (int i = 0; i < 12; i++) tick();
        check("cont_no_second", {hi, lo}, {32'h0, 32'hC});
        check("cont_idle", 64'(busy), 64'd0);

        // Start together with hilo_we in IDLE: operation runs, mt write dropped.
        hilo_we = 1'b1; hilo_sel = 1'b0;
        issue(2'b01, 32'd5, 32'd6);
        hilo_we = 1'b0;
        check("both_lo_kept", 64'(lo), 64'hC);
        check("both_busy", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("both_cycles", 64'(n), 64'd5);
        check("both_result", {hi, lo}, {32'h0, 32'h1E});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
